// File: rtl/xadc_avg_sampler_if.sv
// DRP-side signal bundle between the XADC wizard and xadc_avg_sampler.
// master: the sampler issuing reads; slave: the XADC (or a model of it).
interface xadc_avg_sampler_if;
    logic        eoc;
    logic        drdy;
    logic [15:0] do_in;
    logic        den;
    logic [6:0]  daddr;

    modport master (
        input  eoc,
        input  drdy,
        input  do_in,
        output den,
        output daddr
    );

    modport slave (
        output eoc,
        output drdy,
        output do_in,
        input  den,
        input  daddr
    );
endinterface

// File: rtl/xadc_avg_sampler.sv
// XADC DRP read sequencer with 2^LOG2_AVG boxcar averaging and optional LED thermometer bar.
// Define XADC_AVG_LED_BAR_EN to build the LED bar; otherwise LED is tied to zero.
module xadc_avg_sampler #(
    parameter int unsigned LOG2_AVG  = 4,
    parameter logic [6:0]  CHAN_ADDR = 7'h16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                      CLK100MHZ,
    input  logic                      rst_n,
    xadc_avg_sampler_if.master        drp,
    output logic [11:0]               sample,
    output logic                      sample_valid,
    output logic                      timeout_err,
    output logic                      overrun,
    output logic [15:0]               LED
);

    localparam int unsigned AccW = 12 + LOG2_AVG;
    // Keep the counter at least one bit wide so LOG2_AVG=0 still elaborates.
    localparam int unsigned CntW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((1 << LOG2_AVG) - 1);

    typedef enum logic {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic            den_q, den_d;
    logic [15:0]     tmo_q, tmo_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [11:0]     sample_q, sample_d;
    logic            valid_q, valid_d;
    logic            terr_q, terr_d;
    logic            ovr_q, ovr_d;

    logic [11:0]     code;
    logic [AccW-1:0] sum;
    logic            unused_lsb;

    assign code       = drp.do_in[15:4];
    assign sum        = acc_q + AccW'(code);
    assign unused_lsb = ^drp.do_in[3:0];

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            den_q    <= 1'b0;
            tmo_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            terr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            den_q    <= den_d;
            tmo_q    <= tmo_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            terr_q   <= terr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        den_d    = 1'b0;
        tmo_d    = tmo_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        terr_d   = terr_q;
        ovr_d    = ovr_q;
        unique case (state_q)
            StIdle: begin
                if (drp.eoc) begin
                    den_d   = 1'b1;
                    tmo_d   = 16'(TIMEOUT);
                    state_d = StWait;
                end
            end
            StWait: begin
                // Any eoc while a read is outstanding is dropped, even alongside drdy.
                if (drp.eoc) ovr_d = 1'b1;
                if (drp.drdy) begin
                    state_d = StIdle;
                    tmo_d   = '0;
                    if (cnt_q == CntLast) begin
                        sample_d = 12'(sum >> LOG2_AVG);
                        valid_d  = 1'b1;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (tmo_q == '0) begin
                    terr_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign drp.den      = den_q;
    assign drp.daddr    = CHAN_ADDR;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign timeout_err  = terr_q;
    assign overrun      = ovr_q;

`ifdef XADC_AVG_LED_BAR_EN
    always_comb begin
        LED = '0;
        for (int i = 0; i < 16; i++) begin
            LED[i] = (4'(i) <= sample_q[11:8]);
        end
    end
`else
    assign LED = 16'h0000;
`endif

endmodule

// File: tb/tb_xadc_avg_sampler.sv
// Scoreboard bench: two samplers (LOG2_AVG=4 and LOG2_AVG=0) driven by one directed DRP stimulus.
module tb_xadc_avg_sampler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        eoc, drdy;
    logic [15:0] do_in;

    always #5 clk = ~clk;

    xadc_avg_sampler_if drp_a ();
    xadc_avg_sampler_if drp_b ();

    assign drp_a.eoc   = eoc;
    assign drp_a.drdy  = drdy;
    assign drp_a.do_in = do_in;
    assign drp_b.eoc   = eoc;
    assign drp_b.drdy  = drdy;
    assign drp_b.do_in = do_in;

    logic [11:0] sample_a, sample_b;
    logic        valid_a, valid_b, terr_a, terr_b, ovr_a, ovr_b;
    logic [15:0] led_a, led_b;

    xadc_avg_sampler #(.LOG2_AVG(4), .CHAN_ADDR(7'h16), .TIMEOUT(255)) dut_a (
        .CLK100MHZ    (clk),
        .rst_n        (rst_n),
        .drp          (drp_a),
        .sample       (sample_a),
        .sample_valid (valid_a),
        .timeout_err  (terr_a),
        .overrun      (ovr_a),
        .LED          (led_a)
    );

    xadc_avg_sampler #(.LOG2_AVG(0), .CHAN_ADDR(7'h16), .TIMEOUT(255)) dut_b (
        .CLK100MHZ    (clk),
        .rst_n        (rst_n),
        .drp          (drp_b),
        .sample       (sample_b),
        .sample_valid (valid_b),
        .timeout_err  (terr_b),
        .overrun      (ovr_b),
        .LED          (led_b)
    );

    int checks = 0;
    int errors = 0;
    int den_a = 0, den_b = 0, den_exp = 0;
    logic [11:0] qa[$];
    logic [11:0] qb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] led_exp(input logic [11:0] s);
`ifdef XADC_AVG_LED_BAR_EN
        return 16'hFFFF >> (4'd15 - s[11:8]);
`else
        return 16'h0000;
`endif
    endfunction

    // Monitor: pops the scoreboard whenever a DUT presents a sample.
    always @(negedge clk) begin : monitor
        logic [11:0] ea, eb;
        if (drp_a.den === 1'b1) den_a++;
        if (drp_b.den === 1'b1) den_b++;
        if (valid_a === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_valid: unexpected sample_valid with sample %0h, none expected",
                         sample_a);
            end else begin
                ea = qa.pop_front();
                check("a_sample", 32'(sample_a), 32'(ea));
                check("a_led", 32'(led_a), 32'(led_exp(ea)));
            end
        end
        if (valid_b === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_valid: unexpected sample_valid with sample %0h, none expected",
                         sample_b);
            end else begin
                eb = qb.pop_front();
                check("b_sample", 32'(sample_b), 32'(eb));
                check("b_led", 32'(led_b), 32'(led_exp(eb)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DRP read: eoc pulse, drdy 'dly' cycles after den, optional extra eoc at offset 'extra'.
    task automatic rd(input logic [11:0] code, input int dly, input int extra);
        int w;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        den_exp++;
        w = 0;
        while (drp_a.den !== 1'b1 && w < 4) begin
            tick();
            w++;
        end
        check("den_after_eoc", 32'(drp_a.den), 32'd1);
        qb.push_back(code);
        for (int c = 0; c <= dly; c++) begin
            eoc   = (c == extra);
            drdy  = (c == dly);
            do_in = {code, 4'h0};
            tick();
        end
        eoc  = 1'b0;
        drdy = 1'b0;
    endtask

    initial begin
        int cycles;
        int d0;
        rst_n = 1'b0;
        eoc   = 1'b0;
        drdy  = 1'b0;
        do_in = 16'h0000;
        repeat (3) tick();
        check("rst_den", 32'(drp_a.den), 32'd0);
        check("rst_sample", 32'(sample_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_timeout_err", 32'(terr_a), 32'd0);
        check("rst_overrun", 32'(ovr_a), 32'd0);
        check("rst_led", 32'(led_a), 32'(led_exp(12'h000)));
        check("daddr_a", 32'(drp_a.daddr), 32'h16);
        check("daddr_b", 32'(drp_b.daddr), 32'h16);
        check("rst_sample_b", 32'(sample_b), 32'd0);
        rst_n = 1'b1;
        tick();

        // Constant mid-scale block.
        d0 = den_a;
        qa.push_back(12'h800);
        repeat (16) rd(12'h800, 3, -1);
        repeat (2) tick();
        check("den_count_block", 32'(den_a - d0), 32'd16);

        // Ramp with back-to-back eoc every 4 cycles: truncated average, no overrun.
        qa.push_back(12'h007);
        for (int i = 0; i < 16; i++) rd(12'(i), 2, -1);
        repeat (2) tick();
        check("ramp_overrun_a", 32'(ovr_a), 32'd0);
        check("ramp_overrun_b", 32'(ovr_b), 32'd0);

        // drdy never returned.
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        den_exp++;
        cycles = 0;
        while (terr_a !== 1'b1 && cycles < 400) begin
            tick();
            cycles++;
        end
        check("timeout_cycles", 32'(cycles), 32'd256);
        check("timeout_err_b", 32'(terr_b), 32'd1);
        qa.push_back(12'h123);
        repeat (16) rd(12'h123, 1, -1);
        repeat (2) tick();
        check("timeout_sticky", 32'(terr_a), 32'd1);
        check("no_overrun_yet", 32'(ovr_a), 32'd0);

        // Overrun: eoc 1 cycle after den, then eoc coinciding with drdy.
        d0 = den_a;
        qa.push_back(12'h040);
        rd(12'h040, 3, 1);
        rd(12'h040, 3, 3);
        repeat (14) rd(12'h040, 3, -1);
        repeat (2) tick();
        check("den_count_overrun", 32'(den_a - d0), 32'd16);
        check("overrun_a", 32'(ovr_a), 32'd1);
        check("overrun_b", 32'(ovr_b), 32'd1);

        // Partial block, then reset mid-read with a late drdy after release.
        repeat (7) rd(12'h123, 2, -1);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        den_exp++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drdy  = 1'b1;
        do_in = 16'h5550;
        tick();
        drdy = 1'b0;
        tick();
        check("post_rst_timeout_err", 32'(terr_a), 32'd0);
        check("post_rst_overrun", 32'(ovr_a), 32'd0);
        check("post_rst_sample", 32'(sample_a), 32'd0);
        qa.push_back(12'hFFF);
        repeat (16) rd(12'hFFF, 2, -1);

        repeat (4) tick();
        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);
        check("den_total_a", 32'(den_a), 32'(den_exp));
        check("den_total_b", 32'(den_b), 32'(den_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
